// File: rtl/zap_mode16_halfword_sequencer_pkg.sv
// Shared types and constants for the compressed-mode halfword sequencer.
// Holds the FSM encoding, the holding-register layout and PC lookahead helpers.
package zap_mode16_halfword_sequencer_pkg;

   localparam logic [31:0] PC_STEP_T   = 32'd4;
   localparam logic [31:0] PC_STEP_A   = 32'd8;
   localparam logic [31:0] PC_HALF_OFS = 32'd2;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LO   = 2'd1,
      SEQ_HI   = 2'd2,
      SEQ_W32  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        abort;
      logic [3:0]  taken;
   } seq_hold_t;

   function automatic logic [31:0] pc_lookahead(input logic [31:0] pc, input logic t);
      return pc + (t ? PC_STEP_T : PC_STEP_A);
   endfunction

   // Aborted words are emitted whole so the abort is reported exactly once.
   function automatic seq_state_t entry_state(input logic t, input logic abort,
                                              input logic pc1);
      if (!t || abort) return SEQ_W32;
      return pc1 ? SEQ_HI : SEQ_LO;
   endfunction

endpackage

// File: rtl/zap_mode16_halfword_sequencer_if.sv
// Fetch-side valid/ready handshake between the fetch stage and the sequencer.
interface zap_mode16_halfword_sequencer_if;

   logic [31:0] i_fetch_data;
   logic [31:0] i_fetch_pc;
   logic        i_fetch_valid;
   logic        i_fetch_abort;
   logic [3:0]  i_fetch_taken;
   logic        o_fetch_ready;

   modport master (
      output i_fetch_data, i_fetch_pc, i_fetch_valid, i_fetch_abort, i_fetch_taken,
      input  o_fetch_ready
   );

   modport slave (
      input  i_fetch_data, i_fetch_pc, i_fetch_valid, i_fetch_abort, i_fetch_taken,
      output o_fetch_ready
   );

endinterface

// File: rtl/zap_mode16_halfword_sequencer.sv
// Splits 32-bit fetch words into address-ordered halfwords in compressed mode,
// passing whole words through otherwise; owns fetch backpressure for that path.
module zap_mode16_halfword_sequencer
   import zap_mode16_halfword_sequencer_pkg::*;
(
   input  logic                                 i_clk,
   input  logic                                 i_reset,
   input  logic                                 i_clear,
   input  logic                                 i_stall,
   input  logic                                 i_cpsr_ff_t,
   zap_mode16_halfword_sequencer_if.slave       fetch,
   output logic [31:0]                          o_instr,
   output logic                                 o_instr_valid,
   output logic [31:0]                          o_pc,
   output logic [31:0]                          o_pc_plus_8,
   output logic                                 o_iabort,
   output logic [1:0]                           o_taken
);

   seq_state_t  state_q, state_d;
   seq_hold_t   hold_q, hold_d;
   logic        hold_t_q, hold_t_d;

   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc8_q, pc8_d;
   logic        iabort_q, iabort_d;
   logic [1:0]  taken_q, taken_d;

   logic        ready;
   logic        accept;
   seq_state_t  entry;

   always_comb begin
      ready = 1'b0;
      if (!i_reset && !i_clear)
         ready = (state_q == SEQ_IDLE) ||
                 (!i_stall && ((state_q == SEQ_HI) || (state_q == SEQ_W32)));
   end

   assign fetch.o_fetch_ready = ready;
   assign accept = fetch.i_fetch_valid && ready;
   assign entry  = entry_state(i_cpsr_ff_t, fetch.i_fetch_abort, fetch.i_fetch_pc[1]);

   // State and holding register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= SEQ_IDLE;
         hold_q   <= '0;
         hold_t_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         hold_t_q <= hold_t_d;
      end
   end

   // Next state; an accept in IDLE during stall still loads, then waits for release
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      hold_t_d = hold_t_q;
      if (accept) begin
         hold_d.data  = fetch.i_fetch_data;
         hold_d.pc    = {fetch.i_fetch_pc[31:2], 1'b0, fetch.i_fetch_pc[0]};
         hold_d.abort = fetch.i_fetch_abort;
         hold_d.taken = fetch.i_fetch_taken;
         hold_t_d     = i_cpsr_ff_t;
      end
      if (i_clear) begin
         state_d = SEQ_IDLE;
      end else begin
         case (state_q)
            SEQ_IDLE: if (accept)   state_d = entry;
            SEQ_LO:   if (!i_stall) state_d = SEQ_HI;
            default:  if (!i_stall) state_d = accept ? entry : SEQ_IDLE;
         endcase
      end
   end

   // Emission values for the registered outputs
   always_comb begin
      instr_d  = instr_q;
      valid_d  = valid_q;
      pc_d     = pc_q;
      pc8_d    = pc8_q;
      iabort_d = iabort_q;
      taken_d  = taken_q;
      if (i_clear) begin
         valid_d  = 1'b0;
         iabort_d = 1'b0;
      end else if (!i_stall) begin
         valid_d  = 1'b0;
         iabort_d = 1'b0;
         case (state_q)
            SEQ_LO: begin
               valid_d = 1'b1;
               instr_d = {16'd0, hold_q.data[15:0]};
               pc_d    = hold_q.pc;
               pc8_d   = pc_lookahead(hold_q.pc, 1'b1);
               taken_d = hold_q.taken[1:0];
            end
            SEQ_HI: begin
               valid_d = 1'b1;
               instr_d = {16'd0, hold_q.data[31:16]};
               pc_d    = hold_q.pc | PC_HALF_OFS;
               pc8_d   = pc_lookahead(hold_q.pc | PC_HALF_OFS, 1'b1);
               taken_d = hold_q.taken[3:2];
            end
            SEQ_W32: begin
               valid_d  = 1'b1;
               instr_d  = hold_q.data;
               pc_d     = hold_q.pc;
               pc8_d    = pc_lookahead(hold_q.pc, hold_t_q);
               iabort_d = hold_q.abort;
               taken_d  = hold_q.taken[1:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         instr_q  <= '0;
         valid_q  <= 1'b0;
         pc_q     <= '0;
         pc8_q    <= '0;
         iabort_q <= 1'b0;
         taken_q  <= '0;
      end else begin
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         pc8_q    <= pc8_d;
         iabort_q <= iabort_d;
         taken_q  <= taken_d;
      end
   end

   assign o_instr       = instr_q;
   assign o_instr_valid = valid_q;
   assign o_pc          = pc_q;
   assign o_pc_plus_8   = pc8_q;
   assign o_iabort      = iabort_q;
   assign o_taken       = taken_q;

endmodule

// File: tb/tb_zap_mode16_halfword_sequencer.sv
// Directed self-checking bench for the compressed-mode halfword sequencer.
module tb_zap_mode16_halfword_sequencer;

   logic        clk;
   logic        i_reset, i_clear, i_stall, i_cpsr_ff_t;
   logic [31:0] o_instr, o_pc, o_pc_plus_8;
   logic        o_instr_valid, o_iabort;
   logic [1:0]  o_taken;
   logic [99:0] outs, exp;
   int          total, bad;

   zap_mode16_halfword_sequencer_if fif();

   zap_mode16_halfword_sequencer dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_clear       (i_clear),
      .i_stall       (i_stall),
      .i_cpsr_ff_t   (i_cpsr_ff_t),
      .fetch         (fif),
      .o_instr       (o_instr),
      .o_instr_valid (o_instr_valid),
      .o_pc          (o_pc),
      .o_pc_plus_8   (o_pc_plus_8),
      .o_iabort      (o_iabort),
      .o_taken       (o_taken)
   );

   // {valid, iabort, taken, instr, pc, pc_plus_8}
   assign outs = {o_instr_valid, o_iabort, o_taken, o_instr, o_pc, o_pc_plus_8};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] d, input logic [31:0] pc,
                      input logic ab, input logic [3:0] tk);
      fif.i_fetch_valid = v;
      fif.i_fetch_data  = d;
      fif.i_fetch_pc    = pc;
      fif.i_fetch_abort = ab;
      fif.i_fetch_taken = tk;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      put(1'b1, 32'h1234_5678, 32'h10, 1'b0, 4'hF);
      step();
      step();
      exp = '0;
      total++; if (outs !== exp) begin bad++; $display("FAIL reset_outs got=%h want=%h", outs, exp); end
      total++; if (fif.o_fetch_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", fif.o_fetch_ready); end
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      i_reset = 1'b0;
      #1;
      total++; if (fif.o_fetch_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", fif.o_fetch_ready); end
   endtask

   task automatic test_halfwords();
      i_cpsr_ff_t = 1'b1;
      put(1'b1, 32'h4770_2001, 32'h100, 1'b0, 4'b1001);
      step();
      put(1'b1, 32'hBD00_B500, 32'h104, 1'b0, 4'b0110);
      #1;
      total++; if (fif.o_fetch_ready !== 1'b0) begin bad++; $display("FAIL lo_ready got=%b want=0", fif.o_fetch_ready); end
      step();
      exp = {1'b1, 1'b0, 2'b01, 32'h0000_2001, 32'h100, 32'h104};
      total++; if (outs !== exp) begin bad++; $display("FAIL w1_lo got=%h want=%h", outs, exp); end
      total++; if (fif.o_fetch_ready !== 1'b1) begin bad++; $display("FAIL hi_ready got=%b want=1", fif.o_fetch_ready); end
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      exp = {1'b1, 1'b0, 2'b10, 32'h0000_4770, 32'h102, 32'h106};
      total++; if (outs !== exp) begin bad++; $display("FAIL w1_hi got=%h want=%h", outs, exp); end
      step();
      exp = {1'b1, 1'b0, 2'b10, 32'h0000_B500, 32'h104, 32'h108};
      total++; if (outs !== exp) begin bad++; $display("FAIL w2_lo got=%h want=%h", outs, exp); end
      step();
      exp = {1'b1, 1'b0, 2'b01, 32'h0000_BD00, 32'h106, 32'h10A};
      total++; if (outs !== exp) begin bad++; $display("FAIL w2_hi got=%h want=%h", outs, exp); end
      step();
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b want=0", o_instr_valid); end
   endtask

   task automatic test_high_start();
      put(1'b1, 32'hAAAA_5555, 32'h202, 1'b0, 4'b1100);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b0, 2'b11, 32'h0000_AAAA, 32'h202, 32'h206};
      total++; if (outs !== exp) begin bad++; $display("FAIL hstart got=%h want=%h", outs, exp); end
      step();
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL hstart_once got=%b want=0", o_instr_valid); end
      total++; if (fif.o_fetch_ready !== 1'b1) begin bad++; $display("FAIL hstart_idle got=%b want=1", fif.o_fetch_ready); end
   endtask

   task automatic test_stall();
      put(1'b1, 32'h2222_1111, 32'h500, 1'b0, 4'b0100);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_1111, 32'h500, 32'h504};
      total++; if (outs !== exp) begin bad++; $display("FAIL st_lo got=%h want=%h", outs, exp); end
      i_stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++; if (fif.o_fetch_ready !== 1'b0) begin bad++; $display("FAIL st_ready%0d got=%b want=0", i, fif.o_fetch_ready); end
         step();
         total++; if (outs !== exp) begin bad++; $display("FAIL st_hold%0d got=%h want=%h", i, outs, exp); end
      end
      i_stall = 1'b0;
      step();
      exp = {1'b1, 1'b0, 2'b01, 32'h0000_2222, 32'h502, 32'h506};
      total++; if (outs !== exp) begin bad++; $display("FAIL st_hi got=%h want=%h", outs, exp); end
      step();
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL st_nodup got=%b want=0", o_instr_valid); end
   endtask

   task automatic test_clear();
      put(1'b1, 32'h4444_3333, 32'h600, 1'b0, 4'h0);
      step();
      i_clear = 1'b1;
      put(1'b1, 32'h6666_5555, 32'h604, 1'b0, 4'h0);
      #1;
      total++; if (fif.o_fetch_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b want=0", fif.o_fetch_ready); end
      step();
      total++; if (outs[99:98] !== 2'b00) begin bad++; $display("FAIL clr_valid got=%b want=00", outs[99:98]); end
      i_clear = 1'b0;
      #1;
      total++; if (fif.o_fetch_ready !== 1'b1) begin bad++; $display("FAIL clr_idle got=%b want=1", fif.o_fetch_ready); end
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_5555, 32'h604, 32'h608};
      total++; if (outs !== exp) begin bad++; $display("FAIL clr_lo got=%h want=%h", outs, exp); end
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_6666, 32'h606, 32'h60A};
      total++; if (outs !== exp) begin bad++; $display("FAIL clr_hi got=%h want=%h", outs, exp); end
      step();
   endtask

   task automatic test_abort();
      put(1'b1, 32'h1234_5678, 32'h300, 1'b1, 4'b0010);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b1, 2'b10, 32'h1234_5678, 32'h300, 32'h0};
      total++; if (outs[99:32] !== exp[99:32]) begin bad++; $display("FAIL abort got=%h want=%h", outs[99:32], exp[99:32]); end
      step();
      total++; if (outs[99:98] !== 2'b00) begin bad++; $display("FAIL abort_once got=%b want=00", outs[99:98]); end
   endtask

   task automatic test_arm_word_and_reset();
      i_cpsr_ff_t = 1'b0;
      put(1'b1, 32'hE3A0_0001, 32'h400, 1'b0, 4'b0011);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b0, 2'b11, 32'hE3A0_0001, 32'h400, 32'h408};
      total++; if (outs !== exp) begin bad++; $display("FAIL arm got=%h want=%h", outs, exp); end
      step();
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL arm_once got=%b want=0", o_instr_valid); end
      i_cpsr_ff_t = 1'b1;
      put(1'b1, 32'h8888_7777, 32'h700, 1'b0, 4'h0);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      i_reset = 1'b1;
      step();
      exp = '0;
      total++; if (outs !== exp) begin bad++; $display("FAIL midrst got=%h want=%h", outs, exp); end
      total++; if (fif.o_fetch_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", fif.o_fetch_ready); end
      i_reset = 1'b0;
      step();
      total++; if (o_instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_drop got=%b want=0", o_instr_valid); end
   endtask

   task automatic test_mode_change();
      i_cpsr_ff_t = 1'b1;
      put(1'b1, 32'hCAFE_BABE, 32'h800, 1'b0, 4'h0);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      i_cpsr_ff_t = 1'b0;
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_BABE, 32'h800, 32'h804};
      total++; if (outs !== exp) begin bad++; $display("FAIL tchg_lo got=%h want=%h", outs, exp); end
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_CAFE, 32'h802, 32'h806};
      total++; if (outs !== exp) begin bad++; $display("FAIL tchg_hi got=%h want=%h", outs, exp); end
      step();
   endtask

   task automatic test_wrap();
      i_cpsr_ff_t = 1'b1;
      put(1'b1, 32'h9999_8888, 32'hFFFF_FFFC, 1'b0, 4'h0);
      step();
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_8888, 32'hFFFF_FFFC, 32'h0000_0000};
      total++; if (outs !== exp) begin bad++; $display("FAIL wrap_lo got=%h want=%h", outs, exp); end
      step();
      exp = {1'b1, 1'b0, 2'b00, 32'h0000_9999, 32'hFFFF_FFFE, 32'h0000_0002};
      total++; if (outs !== exp) begin bad++; $display("FAIL wrap_hi got=%h want=%h", outs, exp); end
      step();
   endtask

   initial begin
      total = 0;
      bad = 0;
      i_reset = 1'b1;
      i_clear = 1'b0;
      i_stall = 1'b0;
      i_cpsr_ff_t = 1'b0;
      put(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      test_reset();
      test_halfwords();
      test_high_start();
      test_stall();
      test_clear();
      test_abort();
      test_arm_word_and_reset();
      test_mode_change();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
